// File: rtl/mc_control_pkg.sv
// Shared types and constants for the multi-cycle control sequencer:
// FSM states, instruction classes, opcodes, ALU codes and fault codes.
package mc_control_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    FAULT  = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    CL_R   = 3'd0,
    CL_BR  = 3'd1,
    CL_SW  = 3'd2,
    CL_LW  = 3'd3,
    CL_LUI = 3'd4,
    CL_I   = 3'd5
  } iclass_t;

  localparam logic [6:0] OP_R   = 7'b1110011;
  localparam logic [6:0] OP_BR  = 7'b1101011;
  localparam logic [6:0] OP_SW  = 7'b1100011;
  localparam logic [6:0] OP_LW  = 7'b1000011;
  localparam logic [6:0] OP_LUI = 7'b0110000;
  localparam logic [6:0] OP_I   = 7'b0011111;

  // R-type codes without a common mnemonic are named after their funct3.
  localparam logic [3:0] ALU_F000  = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_XOR   = 4'b0010;
  localparam logic [3:0] ALU_F101  = 4'b0011;
  localparam logic [3:0] ALU_F110  = 4'b0100;
  localparam logic [3:0] ALU_SUB   = 4'b0101;
  localparam logic [3:0] ALU_ADD   = 4'b0110;
  localparam logic [3:0] ALU_F111  = 4'b0111;
  localparam logic [3:0] ALU_CMPEQ = 4'b1000;
  localparam logic [3:0] ALU_CMPLT = 4'b1001;
  localparam logic [3:0] ALU_LUI   = 4'b1100;

  localparam logic [1:0] FLT_NONE    = 2'b00;
  localparam logic [1:0] FLT_ILLEGAL = 2'b01;
  localparam logic [1:0] FLT_IMEM    = 2'b10;
  localparam logic [1:0] FLT_DMEM    = 2'b11;

endpackage

// File: rtl/mc_alu_decode.sv
// Combinational instruction decoder: opcode/funct3/bit30 to ALU control,
// operand select, writeback source, instruction class and illegal flag.
module mc_alu_decode
  import mc_control_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic       i_bit30,
  output logic [3:0] o_alu_control,
  output logic       o_alusrc,
  output logic       o_mem_to_reg,
  output iclass_t    o_class,
  output logic       o_illegal
);

  always_comb begin
    o_alu_control = ALU_F000;
    o_alusrc      = 1'b0;
    o_mem_to_reg  = 1'b0;
    o_class       = CL_R;
    o_illegal     = 1'b0;
    case (i_opcode)
      OP_R: begin
        o_class = CL_R;
        if (i_bit30) begin
          o_alu_control = ALU_SUB;
        end else begin
          case (i_funct3)
            3'b000:  o_alu_control = ALU_F000;
            3'b001:  o_alu_control = ALU_ADD;
            3'b010:  o_alu_control = ALU_OR;
            3'b100:  o_alu_control = ALU_XOR;
            3'b101:  o_alu_control = ALU_F101;
            3'b110:  o_alu_control = ALU_F110;
            3'b111:  o_alu_control = ALU_F111;
            default: o_illegal     = 1'b1;
          endcase
        end
      end
      OP_BR: begin
        o_class = CL_BR;
        case (i_funct3)
          3'b000:  o_alu_control = ALU_CMPEQ;
          3'b001:  o_alu_control = ALU_CMPLT;
          default: o_illegal     = 1'b1;
        endcase
      end
      OP_SW, OP_LW: begin
        o_class       = (i_opcode == OP_LW) ? CL_LW : CL_SW;
        o_alusrc      = 1'b1;
        o_mem_to_reg  = (i_opcode == OP_LW);
        o_alu_control = ALU_ADD;
        o_illegal     = (i_funct3 != 3'b010);
      end
      OP_LUI: begin
        o_class       = CL_LUI;
        o_alu_control = ALU_LUI;
        o_alusrc      = 1'b1;
      end
      OP_I: begin
        o_class  = CL_I;
        o_alusrc = 1'b1;
        case (i_funct3)
          3'b000:  o_alu_control = ALU_ADD;
          3'b001:  o_alu_control = ALU_OR;
          3'b010:  o_alu_control = ALU_XOR;
          default: o_illegal     = 1'b1;
        endcase
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle control sequencer FETCH/DECODE/EXEC/MEM/WB with memory timeouts.
// Define MC_CONTROL_PERF_EN to add the instret and stall_cnt counters.
module mc_control_fsm
  import mc_control_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [31:0] instr,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        branch_taken,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_sel,
  output logic [3:0]  alu_control,
  output logic        alusrc,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        busy,
  output logic [1:0]  fault
`ifdef MC_CONTROL_PERF_EN
  ,
  output logic [31:0] instret,
  output logic [31:0] stall_cnt
`endif
);

  state_t     r_state, w_next_state, w_retire_state;
  logic [31:0] r_ir;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0] r_fault, w_next_fault;
  logic [3:0] w_alu_control;
  logic       w_alusrc, w_mem_to_reg, w_illegal, w_timeout, w_stall, w_retire;
  iclass_t    w_class;
  logic       w_unused_ir;

  mc_alu_decode u_decode (
    .i_opcode      (r_ir[6:0]),
    .i_funct3      (r_ir[14:12]),
    .i_bit30       (r_ir[30]),
    .o_alu_control (w_alu_control),
    .o_alusrc      (w_alusrc),
    .o_mem_to_reg  (w_mem_to_reg),
    .o_class       (w_class),
    .o_illegal     (w_illegal)
  );

  assign w_unused_ir    = &{1'b0, r_ir[31], r_ir[29:15], r_ir[11:7]};
  assign w_timeout      = (r_cnt == CNT_W'(MEM_TIMEOUT - 1));
  assign w_retire_state = run ? FETCH : IDLE;
  assign w_stall        = ((r_state == FETCH) && !imem_ready) ||
                          ((r_state == MEM) && !dmem_ready);
  assign w_retire       = ((r_state == EXEC) && (w_class == CL_BR)) ||
                          ((r_state == MEM) && (w_class == CL_SW) && dmem_ready) ||
                          (r_state == WB);
  assign fault          = r_fault;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ir    <= '0;
      r_cnt   <= '0;
      r_fault <= FLT_NONE;
    end else begin
      r_state <= w_next_state;
      r_fault <= w_next_fault;
      if ((r_state == FETCH) && imem_ready) r_ir <= instr;
      if (w_next_state != r_state) r_cnt <= '0;
      else if (w_stall)            r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Ready on the limit cycle beats the timeout.
  always_comb begin
    w_next_state = r_state;
    w_next_fault = r_fault;
    case (r_state)
      IDLE:   if (run) w_next_state = FETCH;
      FETCH: begin
        if (imem_ready) w_next_state = DECODE;
        else if (w_timeout) begin
          w_next_state = FAULT;
          w_next_fault = FLT_IMEM;
        end
      end
      DECODE: begin
        if (w_illegal) begin
          w_next_state = FAULT;
          w_next_fault = FLT_ILLEGAL;
        end else begin
          w_next_state = EXEC;
        end
      end
      EXEC: begin
        if (w_class == CL_BR)                              w_next_state = w_retire_state;
        else if ((w_class == CL_SW) || (w_class == CL_LW)) w_next_state = MEM;
        else                                               w_next_state = WB;
      end
      MEM: begin
        if (dmem_ready) w_next_state = (w_class == CL_LW) ? WB : w_retire_state;
        else if (w_timeout) begin
          w_next_state = FAULT;
          w_next_fault = FLT_DMEM;
        end
      end
      WB:      w_next_state = w_retire_state;
      FAULT:   w_next_state = FAULT;
      default: w_next_state = IDLE;
    endcase
  end

  // Memory handshake: a request stays high every cycle until its ready is
  // seen high in the same cycle; ready outside a request cycle is ignored.
  always_comb begin
    imem_req    = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    pc_sel      = 1'b0;
    alu_control = 4'b0000;
    alusrc      = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    busy        = 1'b0;
    if ((r_state == DECODE) || (r_state == EXEC) || (r_state == MEM) || (r_state == WB)) begin
      busy        = 1'b1;
      alu_control = w_alu_control;
      alusrc      = w_alusrc;
      mem_to_reg  = w_mem_to_reg;
    end
    case (r_state)
      FETCH: begin
        busy     = 1'b1;
        imem_req = 1'b1;
        ir_we    = imem_ready;
      end
      EXEC: begin
        if (w_class == CL_BR) begin
          pc_we  = 1'b1;
          pc_sel = branch_taken;
        end
      end
      MEM: begin
        mem_read  = (w_class == CL_LW);
        mem_write = (w_class == CL_SW);
        pc_we     = (w_class == CL_SW) && dmem_ready;
      end
      WB: begin
        reg_write = 1'b1;
        pc_we     = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef MC_CONTROL_PERF_EN
  logic [31:0] r_instret, r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instret   <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_retire) r_instret   <= r_instret + 32'd1;
      if (w_stall)  r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign instret   = r_instret;
  assign stall_cnt = r_stall_cnt;
`else
  logic w_unused_retire;
  assign w_unused_retire = w_retire;
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: instruction vector table with a
// memory responder and scoreboard, plus run-drop and async-reset sequences.
module tb_mc_control_fsm;

  logic        clk = 1'b0;
  logic        rst_n, run, imem_req, imem_ready, dmem_ready, branch_taken;
  logic [31:0] instr;
  logic        ir_we, pc_we, pc_sel, alusrc, mem_to_reg, reg_write;
  logic        mem_read, mem_write, busy;
  logic [3:0]  alu_control;
  logic [1:0]  fault;
`ifdef MC_CONTROL_PERF_EN
  logic [31:0] instret, stall_cnt;
`endif

  always #5 clk = ~clk;

  mc_control_fsm #(.MEM_TIMEOUT(16), .CNT_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .instr        (instr),
    .imem_req     (imem_req),
    .imem_ready   (imem_ready),
    .dmem_ready   (dmem_ready),
    .branch_taken (branch_taken),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .pc_sel       (pc_sel),
    .alu_control  (alu_control),
    .alusrc       (alusrc),
    .mem_to_reg   (mem_to_reg),
    .reg_write    (reg_write),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .busy         (busy),
    .fault        (fault)
`ifdef MC_CONTROL_PERF_EN
    ,
    .instret      (instret),
    .stall_cnt    (stall_cnt)
`endif
  );

  // Expected record: busy cycles until retire/fault, data-request cycles,
  // and the control outputs seen on the retire (or first FAULT) cycle.
  typedef struct {
    logic [31:0] instr;
    logic        bt;
    logic [7:0]  id;
    logic [7:0]  dd;
    logic [1:0]  flt;
    logic [7:0]  cyc;
    logic [7:0]  mc;
    logic [3:0]  alu;
    logic        src;
    logic        m2r;
    logic [1:0]  rw;
    logic        psel;
  } vec_t;

  localparam int W = 27;
  localparam int NV = 26;
  logic [W-1:0] exp_q[$];
  vec_t vecs[NV];
  int n_tests = 0;
  int n_fail  = 0;
  int iw = 0;
  int dw = 0;

  function automatic vec_t mk(input logic [31:0] ins, input logic bt, input logic [7:0] id,
                              input logic [7:0] dd, input logic [1:0] flt, input logic [7:0] cyc,
                              input logic [7:0] mc, input logic [3:0] alu, input logic src,
                              input logic m2r, input logic [1:0] rw, input logic psel);
    vec_t v;
    v.instr = ins; v.bt = bt; v.id = id; v.dd = dd; v.flt = flt; v.cyc = cyc;
    v.mc = mc; v.alu = alu; v.src = src; v.m2r = m2r; v.rw = rw; v.psel = psel;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Memory responder: ready comes after id/dd wait cycles of a request (8'hFF = never).
  task automatic step(input logic [7:0] id, input logic [7:0] dd);
    @(posedge clk); #1;
    imem_ready = imem_req && (iw == int'(id));
    dmem_ready = (mem_read || mem_write) && (dw == int'(dd));
    @(negedge clk);
    if (imem_req) iw = imem_ready ? 0 : iw + 1;
    if (mem_read || mem_write) dw = dmem_ready ? 0 : dw + 1;
  endtask

  task automatic do_reset;
    @(posedge clk); #1;
    rst_n = 1'b0; run = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; branch_taken = 1'b0;
    #2;
    check("reset_outputs", {16'h0, imem_req, ir_we, pc_we, pc_sel, alu_control, alusrc,
                            mem_to_reg, reg_write, mem_read, mem_write, busy, fault}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1; run = 1'b1; iw = 0; dw = 0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int cyc, mc, rw;
    logic done;
    logic [W-1:0] act;
    exp_q.push_back({v.flt, v.cyc, v.mc, v.alu, v.src, v.m2r, v.rw, v.psel});
    instr = v.instr; branch_taken = v.bt;
    cyc = 0; mc = 0; rw = 0; done = 1'b0; act = '1;
    for (int k = 0; k < 80 && !done; k++) begin
      step(v.id, v.dd);
      if (busy) cyc++;
      if (mem_read || mem_write) mc++;
      if (reg_write) rw++;
      if (pc_we || (fault != 2'b00)) begin
        act  = {fault, 8'(cyc), 8'(mc), alu_control, alusrc, mem_to_reg, 2'(rw), pc_sel};
        done = 1'b1;
      end
    end
    check($sformatf("vec%0d", idx), 32'(act), 32'(exp_q.pop_front()));
  endtask

  task automatic post_fault(input logic [1:0] flt, input int idx);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("vec%0d_fault_hold", idx),
            {21'h0, imem_req, ir_we, pc_we, reg_write, mem_read, mem_write, busy, alu_control, fault},
            {30'h0, flt});
    end
  endtask

  task automatic seq_run_drop;
    logic seen;
    do_reset;
    instr = 32'h0000_2063; branch_taken = 1'b0; seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      step(8'd0, 8'd3);
      if (mem_write) run = 1'b0;
      if (pc_we) begin
        check("run_drop_sw_retire", {29'h0, pc_we, pc_sel, mem_write}, 32'h5);
        seen = 1'b1;
      end
    end
    if (!seen) check("run_drop_sw_retire", {29'h0, pc_we, pc_sel, mem_write}, 32'h5);
    for (int k = 0; k < 2; k++) begin
      step(8'd0, 8'd0);
      check("run_drop_idle", {30'h0, busy, imem_req}, 32'h0);
    end
  endtask

  task automatic seq_reset_mid_mem;
    logic seen;
    do_reset;
    instr = 32'h0000_2063; seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      step(8'd0, 8'hFF);
      if (mem_write) seen = 1'b1;
    end
    check("mid_mem_write_high", {31'h0, mem_write}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_mid_mem", {29'h0, mem_write, busy, pc_we}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; run = 1'b0; instr = '0; imem_ready = 1'b0; dmem_ready = 1'b0;
    branch_taken = 1'b0;
    //            instr         bt    id     dd     flt    cyc  mc   alu      src m2r rw   psel
    vecs[0]  = mk(32'h00000073, 1'b0, 8'd0,  8'd0,  2'b00, 4,   0,   4'b0000, 0,  0,  1,   0);
    vecs[1]  = mk(32'h00002043, 1'b0, 8'd0,  8'd3,  2'b00, 8,   4,   4'b0110, 1,  1,  1,   0);
    vecs[2]  = mk(32'h0000006B, 1'b1, 8'd0,  8'd0,  2'b00, 3,   0,   4'b1000, 0,  0,  0,   1);
    vecs[3]  = mk(32'h0000006B, 1'b0, 8'd0,  8'd0,  2'b00, 3,   0,   4'b1000, 0,  0,  0,   0);
    vecs[4]  = mk(32'h0000106B, 1'b1, 8'd1,  8'd0,  2'b00, 4,   0,   4'b1001, 0,  0,  0,   1);
    vecs[5]  = mk(32'h00002063, 1'b0, 8'd0,  8'd2,  2'b00, 6,   3,   4'b0110, 1,  0,  0,   0);
    vecs[6]  = mk(32'h40000073, 1'b0, 8'd2,  8'd0,  2'b00, 6,   0,   4'b0101, 0,  0,  1,   0);
    vecs[7]  = mk(32'h00001073, 1'b0, 8'd0,  8'd0,  2'b00, 4,   0,   4'b0110, 0,  0,  1,   0);
    vecs[8]  = mk(32'h00002073, 1'b0, 8'd0,  8'd0,  2'b00, 4,   0,   4'b0001, 0,  0,  1,   0);
    vecs[9]  = mk(32'h00004073, 1'b0, 8'd0,  8'd0,  2'b00, 4,   0,   4'b0010, 0,  0,  1,   0);
    vecs[10] = mk(32'h00005073, 1'b0, 8'd0,  8'd0,  2'b00, 4,   0,   4'b0011, 0,  0,  1,   0);
    vecs[11] = mk(32'h00006073, 1'b0, 8'd0,  8'd0,  2'b00, 4,   0,   4'b0100, 0,  0,  1,   0);
    vecs[12] = mk(32'h00007073, 1'b0, 8'd0,  8'd0,  2'b00, 4,   0,   4'b0111, 0,  0,  1,   0);
    vecs[13] = mk(32'h00000030, 1'b0, 8'd0,  8'd0,  2'b00, 4,   0,   4'b1100, 1,  0,  1,   0);
    vecs[14] = mk(32'h0000001F, 1'b0, 8'd0,  8'd0,  2'b00, 4,   0,   4'b0110, 1,  0,  1,   0);
    vecs[15] = mk(32'h0000101F, 1'b0, 8'd0,  8'd0,  2'b00, 4,   0,   4'b0001, 1,  0,  1,   0);
    vecs[16] = mk(32'h0000201F, 1'b0, 8'd0,  8'd0,  2'b00, 4,   0,   4'b0010, 1,  0,  1,   0);
    vecs[17] = mk(32'h00000073, 1'b0, 8'd15, 8'd0,  2'b00, 19,  0,   4'b0000, 0,  0,  1,   0);
    vecs[18] = mk(32'h00002043, 1'b0, 8'd0,  8'd15, 2'b00, 20,  16,  4'b0110, 1,  1,  1,   0);
    vecs[19] = mk(32'h40003073, 1'b0, 8'd0,  8'd0,  2'b00, 4,   0,   4'b0101, 0,  0,  1,   0);
    vecs[20] = mk(32'h00000000, 1'b0, 8'd0,  8'd0,  2'b01, 2,   0,   4'b0000, 0,  0,  0,   0);
    vecs[21] = mk(32'h00003073, 1'b0, 8'd0,  8'd0,  2'b01, 2,   0,   4'b0000, 0,  0,  0,   0);
    vecs[22] = mk(32'h0000206B, 1'b1, 8'd0,  8'd0,  2'b01, 2,   0,   4'b0000, 0,  0,  0,   0);
    vecs[23] = mk(32'h0000301F, 1'b0, 8'd0,  8'd0,  2'b01, 2,   0,   4'b0000, 0,  0,  0,   0);
    vecs[24] = mk(32'h00000073, 1'b0, 8'hFF, 8'd0,  2'b10, 16,  0,   4'b0000, 0,  0,  0,   0);
    vecs[25] = mk(32'h00002043, 1'b0, 8'd0,  8'hFF, 2'b11, 19,  16,  4'b0000, 0,  0,  0,   0);

    do_reset;
    for (int i = 0; i < NV; i++) begin
      run_vec(vecs[i], i);
      if (vecs[i].flt != 2'b00) begin
        post_fault(vecs[i].flt, i);
        do_reset;
      end
    end
    seq_run_drop;
    seq_reset_mid_mem;
    do_reset;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
